pipe_buf: RTL

Parametrised elastic buffer for the LoongArch pipeline, the generalised successor of the fixed single-register stage boundaries in the five-stage core. It sits between any two stages (first use: IF→ID fetch queue), carrying a WIDTH-bit stage bus with the core's valid/allowin handshake. It holds up to DEPTH entries in FIFO order and supports a pipeline flush from WB. An optional empty-bypass path lets an entry pass through in the same cycle it arrives.

---
 rtl/pipe_buf_pkg.sv | 15 +
 rtl/pipe_buf_ptr.sv | 44 ++++
 rtl/pipe_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipe_buf_pkg.sv
// pipe_buf_pkg: shared definitions for the pipe_buf elastic stage buffer.
// Holds the default payload width and depth, plus the helper function that
// sizes the read/write pointers (never narrower than one bit, so DEPTH=1
// still has a legal pointer).
package pipe_buf_pkg;

  localparam int PIPE_BUF_WIDTH_DEF = 64;
  localparam int PIPE_BUF_DEPTH_DEF = 4;

  // Pointer width: max(1, $clog2(depth)).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// pipe_buf_ptr: circular index register for pipe_buf.
// Counts 0 .. DEPTH-1 and wraps back to 0, so DEPTH need not be a power of two.
// Ports:
//   clk    in   rising-edge clock
//   resetn in   asynchronous active-low reset (pointer -> 0)
//   clear  in   synchronous return to 0 (takes priority over inc)
//   inc    in   advance by one entry
//   ptr    out  current index, PW bits
module pipe_buf_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_buf.sv
// pipe_buf: elastic FIFO buffer between two pipeline stages using the
// valid/allowin handshake. Holds up to DEPTH entries of WIDTH bits in order;
// a flush discards all content on the next edge.
// Optional feature macro: PIPE_BUF_BYPASS_EN -- when defined, an entry
// arriving at an empty buffer whose consumer is ready passes straight
// through in the same cycle without being stored.
// Ports:
//   clk, resetn (async, active-low)
//   flush                       discard all entries, drop the in-flight input
//   in_valid / in_allowin / in_bus     upstream side
//   out_valid / out_allowin / out_bus  downstream side (out_bus = oldest)
//   count                       occupied entries, $clog2(DEPTH+1) bits
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int WIDTH = PIPE_BUF_WIDTH_DEF,
  parameter int DEPTH = PIPE_BUF_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic [WIDTH-1:0]           in_bus,
  output logic                       out_valid,
  input  logic                       out_allowin,
  output logic [WIDTH-1:0]           out_bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             stored_valid;
  logic             bypass;
  logic             push;
  logic             pop;

  assign stored_valid = (count_q != '0);

  // Combinational from out_allowin so a full buffer can take a new entry in
  // the same cycle its oldest one leaves, keeping one entry/cycle throughput.
  assign in_allowin = (count_q != FULL) | out_allowin;

`ifdef PIPE_BUF_BYPASS_EN
  assign bypass    = ~stored_valid & in_valid & out_allowin & ~flush;
  assign out_valid = stored_valid | bypass;
  assign out_bus   = bypass ? in_bus : mem_q[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = stored_valid;
  assign out_bus   = mem_q[rd_ptr];
`endif

  // A bypassed entry is consumed downstream directly and must not be stored.
  assign push = in_valid & in_allowin & ~flush & ~bypass;
  assign pop  = stored_valid & out_allowin & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= in_bus;
    end
  end

  pipe_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clear  (flush),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clear  (flush),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  assign count = count_q;

endmodule
